// File: rtl/md_unit_ctrl.sv
// Multi-cycle multiply/divide sequencer for the E stage.
// It holds busy for a fixed latency, then commits the latched result to HI/LO.
`timescale 1ns/1ps
module md_unit_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

    // The low 64 bits of a product of sign/zero-extended operands are exact.
    function automatic logic [63:0] mul64(input logic [31:0] x, input logic [31:0] y,
                                          input logic sgn);
        logic [63:0] ex;
        logic [63:0] ey;
        ex = {{32{sgn & x[31]}}, x};
        ey = {{32{sgn & y[31]}}, y};
        return ex * ey;
    endfunction

    // Magnitude division avoids the INT_MIN / -1 overflow; returns {rem, quo}.
    function automatic logic [63:0] div64(input logic [31:0] x, input logic [31:0] y,
                                          input logic sgn);
        logic [31:0] mx;
        logic [31:0] my;
        logic [31:0] q;
        logic [31:0] r;
        mx = (sgn & x[31]) ? (32'd0 - x) : x;
        my = (sgn & y[31]) ? (32'd0 - y) : y;
        if (my == 32'd0) begin
            my = 32'd1;
        end else begin
            my = my;
        end
        q = mx / my;
        r = mx % my;
        if (sgn & (x[31] ^ y[31])) begin
            q = 32'd0 - q;
        end else begin
            q = q;
        end
        if (sgn & x[31]) begin
            r = 32'd0 - r;
        end else begin
            r = r;
        end
        return {r, q};
    endfunction

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] res_hi_q, res_hi_d;
    logic [31:0] res_lo_q, res_lo_d;
    logic        accept_s;

    // Next-state, counter, result latch and HI/LO update.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        accept_s = start & ~req & ~busy_q;

        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            {res_hi_d, res_lo_d} = mul64(a, b, op == OP_MULT);
                            cnt_d   = MULT_LOAD;
                            state_d = RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            // Divide by zero commits the current HI/LO, so they keep their value.
                            if (b == 32'd0) begin
                                res_hi_d = hi_q;
                                res_lo_d = lo_q;
                            end else begin
                                {res_hi_d, res_lo_d} = div64(a, b, op == OP_DIV);
                            end
                            cnt_d   = DIV_LOAD;
                            state_d = RUN;
                        end
                        OP_MTHI: hi_d = a;
                        OP_MTLO: lo_d = a;
                        default: state_d = IDLE;
                    endcase
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    hi_d    = res_hi_q;
                    lo_d    = res_lo_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == RUN) && (cnt_d == 4'd0);
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            res_hi_q <= 32'd0;
            res_lo_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Self-checking bench for md_unit_ctrl: directed plan plus randomized ops
// against a longint-arithmetic reference model of HI/LO and the busy window.
`timescale 1ns/1ps
module tb_md_unit_ctrl;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;

    md_unit_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .reset(reset), .req(req), .start(start), .op(op),
        .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference result of an accepted op applied to the architectural HI/LO.
    task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         inout logic [31:0] mh, inout logic [31:0] ml);
        longint p;
        longint sx;
        longint sy;
        longint q;
        longint r;
        case (o)
            3'd1: begin
                p = longint'($signed(x)) * longint'($signed(y));
                mh = p[63:32];
                ml = p[31:0];
            end
            3'd2: begin
                p = longint'({32'd0, x}) * longint'({32'd0, y});
                mh = p[63:32];
                ml = p[31:0];
            end
            3'd3: begin
                if (y != 32'd0) begin
                    sx = longint'($signed(x));
                    sy = longint'($signed(y));
                    q = sx / sy;
                    r = sx % sy;
                    ml = q[31:0];
                    mh = r[31:0];
                end
            end
            3'd4: begin
                if (y != 32'd0) begin
                    ml = x / y;
                    mh = x % y;
                end
            end
            3'd5: mh = x;
            3'd6: ml = x;
            default: ;
        endcase
    endtask

    // Issue one op, follow its busy window, then compare the committed HI/LO.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic r, input logic noise);
        int n;
        n = 0;
        if (!r && (o == 3'd1 || o == 3'd2)) n = MULT_N;
        if (!r && (o == 3'd3 || o == 3'd4)) n = DIV_N;
        op = o; a = x; b = y; req = r; start = 1'b1;
        step();
        start = 1'b0; req = 1'b0;
        a = $urandom; b = $urandom; op = 3'($urandom_range(0, 7));
        for (int k = 1; k <= n; k++) begin
            chk("busy_run", 32'(busy), 32'd1);
            chk("done_run", 32'(done), 32'(k == n));
            chk("hi_hold", hi, exp_hi);
            chk("lo_hold", lo, exp_lo);
            if (noise) begin
                start = 1'b1;
                req = 1'($urandom_range(0, 1));
                op = 3'($urandom_range(1, 6));
            end
            step();
            start = 1'b0; req = 1'b0;
        end
        if (!r) model(o, x, y, exp_hi, exp_lo);
        chk("busy_after", 32'(busy), 32'd0);
        chk("done_after", 32'(done), 32'd0);
        chk("hi_after", hi, exp_hi);
        chk("lo_after", lo, exp_lo);
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] rb;
        reset = 1'b1; req = 1'b0; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        step();

        issue(3'd1, 32'hFFFFFFFD, 32'd5, 1'b0, 1'b0);
        chk("plan_mult_hi", hi, 32'hFFFFFFFF);
        chk("plan_mult_lo", lo, 32'hFFFFFFF1);
        issue(3'd2, 32'hFFFFFFFF, 32'd2, 1'b0, 1'b0);
        chk("plan_multu_hi", hi, 32'h00000001);
        chk("plan_multu_lo", lo, 32'hFFFFFFFE);
        issue(3'd3, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0);
        chk("plan_div_lo", lo, 32'hFFFFFFFD);
        chk("plan_div_hi", hi, 32'hFFFFFFFF);
        issue(3'd4, 32'd7, 32'd2, 1'b0, 1'b0);
        chk("plan_divu_lo", lo, 32'd3);
        chk("plan_divu_hi", hi, 32'd1);
        issue(3'd5, 32'h12345678, 32'd0, 1'b0, 1'b0);
        issue(3'd4, 32'd99, 32'd0, 1'b0, 1'b0);
        chk("plan_dz_hi", hi, 32'h12345678);
        issue(3'd1, 32'd3, 32'd4, 1'b1, 1'b0);
        issue(3'd5, 32'hDEADBEEF, 32'd0, 1'b1, 1'b0);
        issue(3'd1, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 1'b1);
        issue(3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b1);
        chk("plan_ovf_lo", lo, 32'h80000000);
        chk("plan_ovf_hi", hi, 32'd0);

        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 7));
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            issue(ro, $urandom, rb, 1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)));
        end

        issue(3'd6, 32'hA5A5A5A5, 32'd0, 1'b0, 1'b0);
        op = 3'd3; a = 32'd1000; b = 32'd7; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk("pre_rst_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_hi", hi, 32'd0);
        chk("mid_rst_lo", lo, 32'd0);
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        @(negedge clk);
        reset = 1'b0;
        step();
        issue(3'd1, 32'hFFFFFFFD, 32'd5, 1'b0, 1'b0);
        chk("post_rst_lo", lo, 32'hFFFFFFF1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
